fetch_unit: RTL and testbench

Instruction-fetch (IF) stage of the five-stage RV64 pipeline. It owns the program counter, issues one 32-bit instruction read per cycle on the instruction bus, and presents the fetched instruction and its PC to the ID stage. It obeys the hazard unit's `stall_IF` (MEM owns the shared bus) and `branch_taken_IF`/`branch_target_IF` (redirect from EX).

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pipeline definitions for the instruction-fetch stage
package fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [ILEN-1:0] NOP_INST_ENC     = 32'h0000_0013;
    localparam logic [XLEN-1:0] INST_BYTES       = 64'd4;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_FAULT = 2'd2
    } if_state_t;

    // Instructions are 4-byte aligned; only the two low address bits matter.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - program counter with reset load, redirect load and +4 advance
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_value,
    input  logic            incr,
    output logic [XLEN-1:0] pc
);

    // Reset beats redirect, redirect beats sequential advance; the add wraps at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + INST_BYTES;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: owns the PC, issues instruction reads, feeds ID
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [ILEN-1:0] NOP_INST = NOP_INST_ENC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_IF,
    input  logic            branch_taken_IF,
    input  logic [XLEN-1:0] branch_target_IF,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_ack,
    input  logic [ILEN-1:0] ibus_rdata,
    output logic            valid_IF,
    output logic [XLEN-1:0] pc_IF,
    output logic [ILEN-1:0] inst_IF,
    output logic            misaligned_IF
);

    if_state_t       state;
    if_state_t       state_next;
    logic [XLEN-1:0] pc;
    logic            target_misaligned;
    logic            fetch_active;
    logic            fetch_hit;

    assign target_misaligned = is_misaligned(branch_target_IF[1:0]);

    // A request is only live while fetching and nothing higher-priority claims the cycle.
    assign fetch_active = (state == IF_FETCH) && !stall_IF && !branch_taken_IF;
    assign fetch_hit    = fetch_active && ibus_ack;

    assign ibus_req  = fetch_active;
    assign ibus_addr = pc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (branch_taken_IF),
        .load_value (branch_target_IF),
        .incr       (fetch_hit),
        .pc         (pc)
    );

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IDLE spends one cycle after reset; misaligned redirects park the stage in FAULT.
    always_comb begin
        state_next = state;
        case (state)
            IF_IDLE: begin
                state_next = IF_FETCH;
            end
            IF_FETCH: begin
                if (branch_taken_IF && target_misaligned) begin
                    state_next = IF_FAULT;
                end
            end
            IF_FAULT: begin
                if (branch_taken_IF) begin
                    state_next = target_misaligned ? IF_FAULT : IF_FETCH;
                end
            end
            default: begin
                state_next = IF_IDLE;
            end
        endcase
    end

    // ID-facing registers: redirect flushes or raises the fault marker, stall freezes,
    // an ack delivers an instruction and a missing ack inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_IF      <= 1'b0;
            pc_IF         <= '0;
            inst_IF       <= NOP_INST;
            misaligned_IF <= 1'b0;
        end else if (branch_taken_IF) begin
            inst_IF <= NOP_INST;
            if (target_misaligned) begin
                valid_IF      <= 1'b1;
                pc_IF         <= branch_target_IF;
                misaligned_IF <= 1'b1;
            end else begin
                valid_IF      <= 1'b0;
                misaligned_IF <= 1'b0;
            end
        end else if (!stall_IF && (state == IF_FETCH)) begin
            if (ibus_ack) begin
                valid_IF      <= 1'b1;
                pc_IF         <= pc;
                inst_IF       <= ibus_rdata;
                misaligned_IF <= 1'b0;
            end else begin
                valid_IF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed vectors
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_IF;
    logic        branch_taken_IF;
    logic [63:0] branch_target_IF;
    logic        ibus_req;
    logic [63:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic        valid_IF;
    logic [63:0] pc_IF;
    logic [31:0] inst_IF;
    logic        misaligned_IF;

    typedef struct {
        int          id;
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;
    int   vec_id;

    localparam logic [63:0] R  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] W  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NP = 32'h0000_0013;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall_IF         (stall_IF),
        .branch_taken_IF  (branch_taken_IF),
        .branch_target_IF (branch_target_IF),
        .ibus_req         (ibus_req),
        .ibus_addr        (ibus_addr),
        .ibus_ack         (ibus_ack),
        .ibus_rdata       (ibus_rdata),
        .valid_IF         (valid_IF),
        .pc_IF            (pc_IF),
        .inst_IF          (inst_IF),
        .misaligned_IF    (misaligned_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what the DUT must show at mid-cycle.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [63:0] t,
                       input logic a, input logic [31:0] d,
                       input logic e_req, input logic [63:0] e_addr, input logic e_valid,
                       input logic [63:0] e_pc, input logic [31:0] e_inst, input logic e_mis);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        stall_IF         = s;
        branch_taken_IF  = b;
        branch_target_IF = t;
        ibus_ack         = a;
        ibus_rdata       = d;
        e.id    = vec_id;
        e.req   = e_req;
        e.addr  = e_addr;
        e.valid = e_valid;
        e.pc    = e_pc;
        e.inst  = e_inst;
        e.mis   = e_mis;
        sb.push_back(e);
        vec_id = vec_id + 1;
    endtask

    // Monitor: compares the oldest expectation against the DUT on every falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ibus_req",      e.id, {63'd0, ibus_req},      {63'd0, e.req});
            chk("ibus_addr",     e.id, ibus_addr,              e.addr);
            chk("valid_IF",      e.id, {63'd0, valid_IF},      {63'd0, e.valid});
            chk("pc_IF",         e.id, pc_IF,                  e.pc);
            chk("inst_IF",       e.id, {32'd0, inst_IF},       {32'd0, e.inst});
            chk("misaligned_IF", e.id, {63'd0, misaligned_IF}, {63'd0, e.mis});
        end
    end

    initial begin
        total            = 0;
        passed           = 0;
        vec_id           = 0;
        rst              = 1'b1;
        stall_IF         = 1'b0;
        branch_taken_IF  = 1'b0;
        branch_target_IF = '0;
        ibus_ack         = 1'b0;
        ibus_rdata       = '0;
        repeat (2) @(posedge clk);

        //  rst stall br target           ack rdata         req addr              valid pc_IF             inst         mis
        // reset state, then IDLE cycle, then zero-wait stream 0x11/0x22/0x33
        cyc(1, 0, 0, 64'h0,            0, 32'h0,         0, R,                 0, 64'h0,             NP,          0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         0, R,                 0, 64'h0,             NP,          0);
        cyc(0, 0, 0, 64'h0,            1, 32'h11,        1, R,                 0, 64'h0,             NP,          0);
        cyc(0, 0, 0, 64'h0,            1, 32'h22,        1, R + 64'h4,         1, R,                 32'h11,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'h33,        1, R + 64'h8,         1, R + 64'h4,         32'h22,      0);
        // ack withheld three cycles at ...0C
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, R + 64'hC,         1, R + 64'h8,         32'h33,      0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, R + 64'hC,         0, R + 64'h8,         32'h33,      0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, R + 64'hC,         0, R + 64'h8,         32'h33,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'h44,        1, R + 64'hC,         0, R + 64'h8,         32'h33,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'h55,        1, R + 64'h10,        1, R + 64'hC,         32'h44,      0);
        // stall four cycles: no request, outputs frozen, stray ack ignored
        cyc(0, 1, 0, 64'h0,            1, 32'hDEAD,      0, R + 64'h14,        1, R + 64'h10,        32'h55,      0);
        cyc(0, 1, 0, 64'h0,            1, 32'hDEAD,      0, R + 64'h14,        1, R + 64'h10,        32'h55,      0);
        cyc(0, 1, 0, 64'h0,            1, 32'hDEAD,      0, R + 64'h14,        1, R + 64'h10,        32'h55,      0);
        cyc(0, 1, 0, 64'h0,            1, 32'hDEAD,      0, R + 64'h14,        1, R + 64'h10,        32'h55,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'h66,        1, R + 64'h14,        1, R + 64'h10,        32'h55,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'h77,        1, R + 64'h18,        1, R + 64'h14,        32'h66,      0);
        // aligned redirect with a same-cycle ack: data dropped, bubble, new address
        cyc(0, 0, 1, 64'h8000_1000,    1, 32'h88,        0, R + 64'h1C,        1, R + 64'h18,        32'h77,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'h99,        1, 64'h8000_1000,     0, R + 64'h18,        NP,          0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, 64'h8000_1004,     1, 64'h8000_1000,     32'h99,      0);
        // misaligned redirect: fault marker, no requests until an aligned redirect
        cyc(0, 0, 1, 64'h8000_2002,    0, 32'h0,         0, 64'h8000_1004,     0, 64'h8000_1000,     32'h99,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'hBAD,       0, 64'h8000_2002,     1, 64'h8000_2002,     NP,          1);
        cyc(0, 0, 0, 64'h0,            1, 32'hBAD,       0, 64'h8000_2002,     1, 64'h8000_2002,     NP,          1);
        cyc(0, 0, 1, 64'h8000_3000,    0, 32'h0,         0, 64'h8000_2002,     1, 64'h8000_2002,     NP,          1);
        cyc(0, 0, 0, 64'h0,            1, 32'hAA,        1, 64'h8000_3000,     0, 64'h8000_2002,     NP,          0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, 64'h8000_3004,     1, 64'h8000_3000,     32'hAA,      0);
        // PC at all-ones-3 with redirect+stall+ack: redirect wins, fetch waits for stall
        cyc(0, 0, 1, W,                0, 32'h0,         0, 64'h8000_3004,     0, 64'h8000_3000,     32'hAA,      0);
        cyc(0, 1, 1, 64'h8000_4000,    1, 32'hBB,        0, W,                 0, 64'h8000_3000,     NP,          0);
        cyc(0, 1, 0, 64'h0,            1, 32'hBB,        0, 64'h8000_4000,     0, 64'h8000_3000,     NP,          0);
        cyc(0, 0, 0, 64'h0,            1, 32'hCC,        1, 64'h8000_4000,     0, 64'h8000_3000,     NP,          0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, 64'h8000_4004,     1, 64'h8000_4000,     32'hCC,      0);
        // PC wraps from all-ones-3 to zero on an ack
        cyc(0, 0, 1, W,                0, 32'h0,         0, 64'h8000_4004,     0, 64'h8000_4000,     32'hCC,      0);
        cyc(0, 0, 0, 64'h0,            1, 32'hDD,        1, W,                 0, 64'h8000_4000,     NP,          0);
        cyc(0, 0, 0, 64'h0,            1, 32'hEE,        1, 64'h0,             1, W,                 32'hDD,      0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, 64'h4,             1, 64'h0,             32'hEE,      0);
        // reset during a pending request, late ack ignored, restart from RESET_PC
        cyc(1, 0, 0, 64'h0,            0, 32'h0,         1, 64'h4,             0, 64'h0,             32'hEE,      0);
        cyc(1, 0, 0, 64'h0,            1, 32'hFF,        0, R,                 0, 64'h0,             NP,          0);
        cyc(0, 0, 0, 64'h0,            1, 32'hFF,        0, R,                 0, 64'h0,             NP,          0);
        cyc(0, 0, 0, 64'h0,            1, 32'h12,        1, R,                 0, 64'h0,             NP,          0);
        cyc(0, 0, 0, 64'h0,            0, 32'h0,         1, R + 64'h4,         1, R,                 32'h12,      0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", -1, 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
